// File: rtl/cache_write_through_buffer.sv
// cache_write_through_buffer: write-through store FIFO between the cache
// front-end store path and the back-end write channel.
// Stores leave in program order. The head entry is presented combinationally
// from storage, so it stays stable while the back-end holds off.
// Optional feature: define CACHE_WTB_COALESCE_EN to merge a store into the
// most recently queued entry when the word addresses match.
module cache_write_through_buffer #(
  parameter int FE_ADDR_W = 32,
  parameter int FE_DATA_W = 32,
  parameter int FE_NBYTES = FE_DATA_W / 8,
  parameter int FE_BYTE_W = $clog2(FE_NBYTES),
  parameter int DEPTH_W   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [FE_ADDR_W-FE_BYTE_W-1:0] push_addr,
  input  logic [FE_DATA_W-1:0]           push_wdata,
  input  logic [FE_NBYTES-1:0]           push_wstrb,
  output logic                           full,
  output logic                           empty,
  output logic                           write_valid,
  output logic [FE_ADDR_W-FE_BYTE_W-1:0] write_addr,
  output logic [FE_DATA_W-1:0]           write_wdata,
  output logic [FE_NBYTES-1:0]           write_wstrb,
  input  logic                           write_ready
);

  localparam int DEPTH = 1 << DEPTH_W;
  localparam int AW    = FE_ADDR_W - FE_BYTE_W;

  logic [AW-1:0]        addr_q [DEPTH];
  logic [FE_DATA_W-1:0] data_q [DEPTH];
  logic [FE_NBYTES-1:0] strb_q [DEPTH];

  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W:0]   count;

  logic do_push;
  logic do_pop;
  logic do_merge;

  // Count never exceeds DEPTH, so its top bit alone marks the full state.
  assign full        = count[DEPTH_W];
  assign empty       = (count == '0);
  assign write_valid = ~empty;
  assign write_addr  = addr_q[rd_ptr];
  assign write_wdata = data_q[rd_ptr];
  assign write_wstrb = strb_q[rd_ptr];

  assign do_pop  = write_ready & ~empty;
  // full is sampled before any same-cycle pop, so a push while full waits a cycle.
  assign do_push = push & ~full & ~do_merge;

`ifdef CACHE_WTB_COALESCE_EN
  logic [DEPTH_W-1:0] last_ptr;

  // With at least two entries queued the newest one is never the head, so it
  // can be rewritten without disturbing the word the back-end is reading.
  assign last_ptr = wr_ptr - DEPTH_W'(1);
  assign do_merge = push && (count >= (DEPTH_W+1)'(2)) && (push_addr == addr_q[last_ptr]);
`else
  assign do_merge = 1'b0;
`endif

  // Entry storage: allocate at the write pointer, or merge into the newest entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        addr_q[wr_ptr] <= push_addr;
        data_q[wr_ptr] <= push_wdata;
        strb_q[wr_ptr] <= push_wstrb;
      end
`ifdef CACHE_WTB_COALESCE_EN
      if (do_merge) begin
        for (int b = 0; b < FE_NBYTES; b++) begin
          if (push_wstrb[b]) data_q[last_ptr][8*b +: 8] <= push_wdata[8*b +: 8];
        end
        strb_q[last_ptr] <= strb_q[last_ptr] | push_wstrb;
      end
`endif
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_W+1)'(1);
        2'b01:   count <= count - (DEPTH_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_write_through_buffer.sv
// Self-checking bench for cache_write_through_buffer (default parameters).
// Hand-written vector table, reset/coalesce sequences, and a randomized run
// against a queue-based reference model.
module tb_cache_write_through_buffer;

  localparam int AW = 30;

  logic        clk = 1'b0;
  logic        reset;
  logic        push;
  logic [29:0] push_addr;
  logic [31:0] push_wdata;
  logic [3:0]  push_wstrb;
  logic        full;
  logic        empty;
  logic        write_valid;
  logic [29:0] write_addr;
  logic [31:0] write_wdata;
  logic [3:0]  write_wstrb;
  logic        write_ready;

  int checks = 0;
  int errors = 0;

  cache_write_through_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_addr   (push_addr),
    .push_wdata  (push_wdata),
    .push_wstrb  (push_wstrb),
    .full        (full),
    .empty       (empty),
    .write_valid (write_valid),
    .write_addr  (write_addr),
    .write_wdata (write_wdata),
    .write_wstrb (write_wstrb),
    .write_ready (write_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        p;
    logic [29:0] a;
    logic        r;
    logic        ev;
    logic        ef;
    logic        ee;
    logic [29:0] ea;
  } vec_t;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  ent_t mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [29:0] a);
    if (a == 30'h100) return 32'hDEAD_BEEF;
    return 32'h5A00_0000 | {2'b00, a};
  endfunction

  // Drive inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic p, input logic [29:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic r);
    push = p; push_addr = a; push_wdata = d; push_wstrb = s; write_ready = r;
    @(posedge clk);
    #1;
    push = 1'b0; write_ready = 1'b0;
  endtask

  task automatic do_reset();
    push = 1'b0; write_ready = 1'b0; push_addr = '0; push_wdata = '0; push_wstrb = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mq.delete();
  endtask

  // Reference model: one clock of FIFO behaviour using the pre-edge state.
  task automatic model_step(input logic p, input logic [29:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic r);
    int   n;
    bit   merged;
    ent_t e;
    n = mq.size();
    merged = 0;
`ifdef CACHE_WTB_COALESCE_EN
    if (p && n >= 2 && mq[n-1].addr == a) begin
      e = mq[n-1];
      for (int b = 0; b < 4; b++) if (s[b]) e.data[8*b +: 8] = d[8*b +: 8];
      e.strb = e.strb | s;
      mq[n-1] = e;
      merged = 1;
    end
`endif
    if (r && n > 0) void'(mq.pop_front());
    if (p && !merged && n < 4) begin
      e.addr = a; e.data = d; e.strb = s;
      mq.push_back(e);
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_valid"}, 64'(write_valid), 64'(mq.size() != 0));
    chk({tag, "_full"},  64'(full),        64'(mq.size() == 4));
    chk({tag, "_empty"}, 64'(empty),       64'(mq.size() == 0));
    if (mq.size() != 0) begin
      chk({tag, "_addr"}, 64'(write_addr),  64'(mq[0].addr));
      chk({tag, "_data"}, 64'(write_wdata), 64'(mq[0].data));
      chk({tag, "_strb"}, 64'(write_wstrb), 64'(mq[0].strb));
    end
  endtask

  vec_t vt[$];

  function automatic vec_t mk(input logic p, input logic [29:0] a, input logic r,
                              input logic ev, input logic ef, input logic ee,
                              input logic [29:0] ea);
    vec_t v;
    v.p = p; v.a = a; v.r = r; v.ev = ev; v.ef = ef; v.ee = ee; v.ea = ea;
    return v;
  endfunction

  initial begin
    logic        p, r;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;

    // Single store, held three cycles, then drained.
    vt.push_back(mk(1, 30'h100, 0, 1, 0, 0, 30'h100));
    vt.push_back(mk(0, 30'h0,   0, 1, 0, 0, 30'h100));
    vt.push_back(mk(0, 30'h0,   0, 1, 0, 0, 30'h100));
    vt.push_back(mk(0, 30'h0,   1, 0, 0, 1, 30'h0));
    // Fill, overflow, full with simultaneous pop, then drain in order.
    vt.push_back(mk(1, 30'h10,  0, 1, 0, 0, 30'h10));
    vt.push_back(mk(1, 30'h11,  0, 1, 0, 0, 30'h10));
    vt.push_back(mk(1, 30'h12,  0, 1, 0, 0, 30'h10));
    vt.push_back(mk(1, 30'h13,  0, 1, 1, 0, 30'h10));
    vt.push_back(mk(1, 30'h14,  0, 1, 1, 0, 30'h10));
    vt.push_back(mk(1, 30'h14,  1, 1, 0, 0, 30'h11));
    vt.push_back(mk(1, 30'h14,  0, 1, 1, 0, 30'h11));
    vt.push_back(mk(0, 30'h0,   1, 1, 0, 0, 30'h12));
    vt.push_back(mk(0, 30'h0,   1, 1, 0, 0, 30'h13));
    vt.push_back(mk(0, 30'h0,   1, 1, 0, 0, 30'h14));
    vt.push_back(mk(0, 30'h0,   1, 0, 0, 1, 30'h0));
    // Push while empty with ready set: only the push applies.
    vt.push_back(mk(1, 30'h20,  1, 1, 0, 0, 30'h20));
    vt.push_back(mk(1, 30'h21,  1, 1, 0, 0, 30'h21));
    vt.push_back(mk(1, 30'h22,  0, 1, 0, 0, 30'h21));
    // Back-to-back drain with concurrent push, two entries held.
    vt.push_back(mk(1, 30'h30,  1, 1, 0, 0, 30'h22));
    vt.push_back(mk(1, 30'h31,  1, 1, 0, 0, 30'h30));
    vt.push_back(mk(1, 30'h32,  1, 1, 0, 0, 30'h31));
    vt.push_back(mk(1, 30'h33,  1, 1, 0, 0, 30'h32));
    vt.push_back(mk(1, 30'h34,  1, 1, 0, 0, 30'h33));
    vt.push_back(mk(1, 30'h35,  1, 1, 0, 0, 30'h34));
    vt.push_back(mk(0, 30'h0,   1, 1, 0, 0, 30'h35));
    vt.push_back(mk(0, 30'h0,   1, 0, 0, 1, 30'h0));

    do_reset();
    chk("rst_valid", 64'(write_valid), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full",  64'(full), 64'(0));
    chk("rst_addr",  64'(write_addr), 64'(0));
    chk("rst_data",  64'(write_wdata), 64'(0));
    chk("rst_strb",  64'(write_wstrb), 64'(0));

    foreach (vt[i]) begin
      cyc(vt[i].p, vt[i].a, data_of(vt[i].a), 4'hF, vt[i].r);
      chk($sformatf("vec%0d_valid", i), 64'(write_valid), 64'(vt[i].ev));
      chk($sformatf("vec%0d_full", i),  64'(full),        64'(vt[i].ef));
      chk($sformatf("vec%0d_empty", i), 64'(empty),       64'(vt[i].ee));
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_addr", i), 64'(write_addr),  64'(vt[i].ea));
        chk($sformatf("vec%0d_data", i), 64'(write_wdata), 64'(data_of(vt[i].ea)));
        chk($sformatf("vec%0d_strb", i), 64'(write_wstrb), 64'(4'hF));
      end
    end

    // Asynchronous reset mid-operation with three entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 30'h60 + 30'(i), 32'h6000 + 32'(i), 4'hF, 0);
    chk("pre_rst_valid", 64'(write_valid), 64'(1));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(write_valid), 64'(0));
    chk("async_rst_empty", 64'(empty), 64'(1));
    chk("async_rst_addr",  64'(write_addr), 64'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    mq.delete();
    cyc(1, 30'h55, 32'h55, 4'hF, 0);
    chk("post_rst_addr", 64'(write_addr), 64'(30'h55));
    chk("post_rst_data", 64'(write_wdata), 64'(32'h55));
    cyc(0, 30'h0, 32'h0, 4'h0, 1);
    chk("post_rst_empty", 64'(empty), 64'(1));

`ifdef CACHE_WTB_COALESCE_EN
    do_reset();
    cyc(1, 30'h20, 32'h11,   4'h1, 0);
    cyc(1, 30'h30, 32'h22,   4'h1, 0);
    cyc(1, 30'h30, 32'h3300, 4'h2, 0);
    chk("coal_head", 64'(write_addr), 64'(30'h20));
    cyc(0, 30'h0, 32'h0, 4'h0, 1);
    chk("coal_addr", 64'(write_addr), 64'(30'h30));
    chk("coal_data", 64'(write_wdata), 64'(32'h3322));
    chk("coal_strb", 64'(write_wstrb), 64'(4'h3));
    cyc(0, 30'h0, 32'h0, 4'h0, 1);
    chk("coal_empty", 64'(empty), 64'(1));
`endif

    // Randomized run against the reference model; small address set so
    // repeated addresses occur often.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      p = 1'($urandom_range(0, 99) < 60);
      r = 1'($urandom_range(0, 99) < 45);
      a = 30'h40 + 30'($urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom);
      model_step(p, a, d, s, r);
      cyc(p, a, d, s, r);
      model_check($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_write_through_buffer.md
Name: cache_write_through_buffer

Overview:
- FIFO between the cache front-end's store path and the back-end write channel, operating in write-through mode (WRITE_POL = 0).
- Queues word stores (address, data, byte strobes) so the front-end can retire a write in one cycle.
- Drains the queue one entry at a time into the back-end write interface, in program order.
- Exposes full/empty so the cache controller can stall stores and order read misses behind pending writes.

Parameters:
- FE_ADDR_W, 32, front-end byte-address width.
- FE_DATA_W, 32, front-end word width.
- FE_NBYTES, FE_DATA_W/8, bytes per word.
- FE_BYTE_W, $clog2(FE_NBYTES), byte-offset bits dropped from the address.
- DEPTH_W, 2, log2 of entry count (default 4 entries); legal range 1..8.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- push  input  1  front-end store request; qualified by ~full
- push_addr  input  FE_ADDR_W-FE_BYTE_W  word address [FE_ADDR_W-1:FE_BYTE_W]
- push_wdata  input  FE_DATA_W  store data
- push_wstrb  input  FE_NBYTES  byte enables
- full  output  1  no free entry
- empty  output  1  no pending entry
- write_valid  output  1  head entry present for the back-end
- write_addr  output  FE_ADDR_W-FE_BYTE_W  head address
- write_wdata  output  FE_DATA_W  head data
- write_wstrb  output  FE_NBYTES  head strobes
- write_ready  input  1  back-end has completed the head write

Behaviour:
- Reset:
  - Asynchronous and active-high; one clock domain (clk).
  - Pointers and count clear to 0; empty=1, full=0, write_valid=0.
  - write_addr, write_wdata and write_wstrb read as 0; all storage entries clear to 0.
  - Reset asserted mid-drain discards all entries; write_valid drops with reset, no partial state survives.
- Storage:
  - 2**DEPTH_W entries.
  - Write pointer, read pointer: DEPTH_W bits, wrap modulo depth.
  - Occupancy counter: DEPTH_W+1 bits.
  - full = (count == 2**DEPTH_W); empty = (count == 0); both are decoded from registered state, with no combinational path from push or write_ready.
- Push:
  - Accepted on a rising edge with push=1 and full=0. The entry is written at the write pointer, then the write pointer and count increment.
  - push=1 while full=1 is ignored; no state changes and the stored data is unchanged. The front-end must hold the store.
- Drain:
  - write_valid = ~empty. write_addr/wdata/wstrb are driven from the entry at the read pointer.
  - Outputs stay stable while write_valid=1 and write_ready=0.
  - Pop occurs on an edge with write_ready=1 and write_valid=1: the read pointer increments and count decrements.
  - write_ready while empty is ignored.
- Latency:
  - A push into an empty buffer at edge N gives write_valid=1 after edge N.
  - A pop at edge M presents the next entry, if any, after edge M with no bubble.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - When full, push is still rejected in that cycle, because full is evaluated before the pop. The slot frees for the next cycle.
  - When empty, only the push applies.
- Ordering: strictly FIFO. Entries are never reordered or dropped once accepted.
- Wrap-around: pointers wrap from 2**DEPTH_W-1 to 0 with no loss.

Optional Feature:
- Macro: CACHE_WTB_COALESCE_EN.
- Defined:
  - A push whose push_addr equals the address of the most recently written entry (write pointer - 1) merges into that entry instead of allocating a new one.
  - Merge rule: for each byte with push_wstrb set, the data byte is overwritten; the merged strobe is old strobe OR new strobe. Count is unchanged.
  - Merging is allowed only when count >= 2, so the target is never the head entry being presented.
  - Merging is accepted even when full=1.
- Not defined: no address comparator; every accepted push allocates an entry.

Test Plan:
- Single store: reset, push addr=0x100, wdata=0xDEADBEEF, wstrb=0xF; write_ready=0 for 3 cycles, then 1 -> write_valid high 3 cycles with stable outputs, then low, empty=1.
- Fill/overflow: DEPTH_W=2, push 5 words (0x10..0x14) with write_ready=0 -> full=1 after the 4th push; the 5th push is ignored; the drain returns 0x10..0x13 in order.
- Back-to-back drain with concurrent push: 2 entries queued; hold push=1 and write_ready=1 for 6 cycles -> count stays 2, no gaps, outputs in push order.
- Full plus simultaneous pop: buffer full, push=1 and write_ready=1 on the same edge -> push rejected that cycle, count drops to 3, the push is accepted the following cycle.
- Reset mid-operation: 3 entries queued, assert reset asynchronously between edges -> write_valid=0 and empty=1 immediately; a post-reset push of 0x55 is the first drained entry.
- Coalesce (CACHE_WTB_COALESCE_EN): queue A=0x20 (wstrb 0x1, data 0x11) then B=0x30 (wstrb 0x1, data 0x22); push B again with wstrb 0x2, data 0x3300 -> count=2, second drained entry data 0x3322, wstrb 0x3.
